// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared types, constants and address helpers for the TLB walk/fill engine
package tlb_pkg;

    localparam int NUM_ENTRIES_DEF = 8;
    localparam int VPN_W_DEF       = 20;

    localparam int PTE_P   = 0;
    localparam int PTE_RW  = 1;
    localparam int PTE_PCD = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PDE,
        ST_PTE,
        ST_FILL
    } walk_state_t;

    function automatic logic [31:0] pde_addr(input logic [19:0] cr3, input logic [9:0] dir_idx);
        return {cr3, dir_idx, 2'b00};
    endfunction

    function automatic logic [31:0] pte_addr(input logic [19:0] pt_frame, input logic [9:0] tbl_idx);
        return {pt_frame, tbl_idx, 2'b00};
    endfunction

endpackage

// File: rtl/tlb_walk_fill_if.sv
// rtl/tlb_walk_fill_if.sv - miss request handshake and memory read port of the walk engine
interface tlb_walk_fill_if;
    import tlb_pkg::*;

    logic                 miss_req;
    logic [31:0]          miss_va;
    logic                 miss_ack;
    logic [VPN_W_DEF-1:0] cr3_base;
    logic                 mem_rd_req;
    logic [31:0]          mem_rd_addr;
    logic                 mem_rd_valid;
    logic [31:0]          mem_rd_data;

    modport master (
        output miss_req, miss_va, cr3_base, mem_rd_valid, mem_rd_data,
        input  miss_ack, mem_rd_req, mem_rd_addr
    );

    modport slave (
        input  miss_req, miss_va, cr3_base, mem_rd_valid, mem_rd_data,
        output miss_ack, mem_rd_req, mem_rd_addr
    );

endinterface

// File: rtl/tlb_victim_sel.sv
// rtl/tlb_victim_sel.sv - picks the TLB slot to fill: tag hit, then lowest free, then round-robin
module tlb_victim_sel
    import tlb_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int VPN_W       = VPN_W_DEF,
    parameter int SLOT_W      = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES*VPN_W-1:0] vp,
    input  logic [NUM_ENTRIES-1:0]       valid,
    input  logic [VPN_W-1:0]             vpn,
    input  logic [SLOT_W-1:0]            rr,
    output logic [SLOT_W-1:0]            slot,
    output logic                         use_rr
);

    logic hit;
    logic free;

    // Descending scans so the lowest matching index is the one that sticks.
    always_comb begin
        slot   = '0;
        use_rr = 1'b0;
        hit    = 1'b0;
        free   = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (vp[i*VPN_W +: VPN_W] == vpn)) begin
                hit  = 1'b1;
                slot = SLOT_W'(i);
            end
        end
        if (!hit) begin
            for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
                if (!valid[i]) begin
                    free = 1'b1;
                    slot = SLOT_W'(i);
                end
            end
            if (!free) begin
                slot   = rr;
                use_rr = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlb_walk_fill.sv
// rtl/tlb_walk_fill.sv - two-level page walk engine owning the TLB storage and fill policy
module tlb_walk_fill
    import tlb_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int VPN_W       = VPN_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    tlb_walk_fill_if.slave               bus,
    input  logic                         flush,
    output logic [NUM_ENTRIES*VPN_W-1:0] VP,
    output logic [NUM_ENTRIES*VPN_W-1:0] PF,
    output logic [NUM_ENTRIES-1:0]       entry_v,
    output logic [NUM_ENTRIES-1:0]       entry_P,
    output logic [NUM_ENTRIES-1:0]       entry_RW,
    output logic [NUM_ENTRIES-1:0]       entry_PCD,
    output logic                         walk_done,
    output logic                         page_fault,
    output logic                         busy
);

    localparam int SLOT_W = $clog2(NUM_ENTRIES);

    walk_state_t       state;
    logic [SLOT_W-1:0] rr;
    logic [VPN_W-1:0]  vpn_q;
    logic [VPN_W-1:0]  pf_q;
    logic              pde_rw_q;
    logic              rw_q;
    logic              pcd_q;
    logic [SLOT_W-1:0] slot;
    logic              use_rr;
    logic              accept;

    assign accept       = !rst && (state == ST_IDLE) && bus.miss_req && !flush;
    assign bus.miss_ack = accept;

    tlb_victim_sel #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .VPN_W       (VPN_W),
        .SLOT_W      (SLOT_W)
    ) u_victim_sel (
        .vp     (VP),
        .valid  (entry_v),
        .vpn    (vpn_q),
        .rr     (rr),
        .slot   (slot),
        .use_rr (use_rr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            rr              <= '0;
            vpn_q           <= '0;
            pf_q            <= '0;
            pde_rw_q        <= 1'b0;
            rw_q            <= 1'b0;
            pcd_q           <= 1'b0;
            VP              <= '0;
            PF              <= '0;
            entry_v         <= '0;
            entry_P         <= '0;
            entry_RW        <= '0;
            entry_PCD       <= '0;
            bus.mem_rd_req  <= 1'b0;
            bus.mem_rd_addr <= '0;
            walk_done       <= 1'b0;
            page_fault      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            walk_done  <= 1'b0;
            page_fault <= 1'b0;
            // Flush overrides every state, including a pending fill; tags stay, valids go.
            if (flush) begin
                entry_v        <= '0;
                state          <= ST_IDLE;
                bus.mem_rd_req <= 1'b0;
                busy           <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.miss_req) begin
                            vpn_q           <= bus.miss_va[31:12];
                            bus.mem_rd_req  <= 1'b1;
                            bus.mem_rd_addr <= pde_addr(bus.cr3_base, bus.miss_va[31:22]);
                            busy            <= 1'b1;
                            state           <= ST_PDE;
                        end
                    end
                    ST_PDE: begin
                        if (bus.mem_rd_valid) begin
                            pde_rw_q <= bus.mem_rd_data[PTE_RW];
                            if (!bus.mem_rd_data[PTE_P]) begin
                                page_fault     <= 1'b1;
                                bus.mem_rd_req <= 1'b0;
                                busy           <= 1'b0;
                                state          <= ST_IDLE;
                            end else begin
                                bus.mem_rd_addr <= pte_addr(bus.mem_rd_data[31:12], vpn_q[9:0]);
                                state           <= ST_PTE;
                            end
                        end
                    end
                    ST_PTE: begin
                        if (bus.mem_rd_valid) begin
                            bus.mem_rd_req <= 1'b0;
                            if (!bus.mem_rd_data[PTE_P]) begin
                                page_fault <= 1'b1;
                                busy       <= 1'b0;
                                state      <= ST_IDLE;
                            end else begin
                                pf_q      <= bus.mem_rd_data[31:12];
                                rw_q      <= pde_rw_q & bus.mem_rd_data[PTE_RW];
                                pcd_q     <= bus.mem_rd_data[PTE_PCD];
                                walk_done <= 1'b1;
                                state     <= ST_FILL;
                            end
                        end
                    end
                    ST_FILL: begin
                        VP[int'(slot)*VPN_W +: VPN_W] <= vpn_q;
                        PF[int'(slot)*VPN_W +: VPN_W] <= pf_q;
                        entry_v[slot]   <= 1'b1;
                        entry_P[slot]   <= 1'b1;
                        entry_RW[slot]  <= rw_q;
                        entry_PCD[slot] <= pcd_q;
                        if (use_rr) begin
                            rr <= rr + SLOT_W'(1);
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
